wb_cmd_master: RTL and testbench

- Wishbone classic single-transfer initiator (master) for the user area.
- Converts a valid/ready command stream (from LA probes or a local sequencer) into one WB read or write cycle, then returns the result on a valid/ready response stream.
- Used to drive user-area WB slaves (e.g. counter-style peripherals) independently of the management SoC.
- Includes a 1-deep command register and a 1-deep response register, with optional bus timeout.

---
 rtl/wb_cmd_master.sv | 119 +++++++++++
 tb/tb_wb_cmd_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: valid/ready command in, one WB cycle, valid/ready response out.
// Optional bus timeout abort is enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [3:0]    cmd_sel,
  input  logic [AW-1:0] cmd_adr,
  input  logic [31:0]   cmd_dat,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_dat,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  input  logic [31:0]   wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  output logic          busy
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT must be in 2..65535");
  end

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state;

  logic tmo_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
  logic          rsp_timeout_q;
  assign tmo_hit     = (cnt == CNT_LAST);
  assign rsp_timeout = rsp_timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
      cnt           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            cnt       <= '0;
`endif
            state     <= BUS;
          end
        end
        BUS: begin
          // ack wins over err, err wins over timeout; sel/adr/dat_o stay as last driven
          if (wbm_ack_i || wbm_err_i || tmo_hit) begin
            rsp_dat   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
            rsp_err   <= !wbm_ack_i && wbm_err_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            rsp_timeout_q <= !wbm_ack_i && !wbm_err_i;
`endif
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: transaction timeline model plus per-cycle output comparison.
module tb_wb_cmd_master;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
  logic        busy;

  wb_cmd_master #(.AW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_sel(cmd_sel),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs for the current cycle, written by the driver just after each rising edge
  logic        chk_en = 1'b0;
  logic        exp_cyc, exp_we, exp_ready, exp_rvalid, exp_rerr, exp_rto;
  logic        exp_chk_bus, exp_chk_rsp;
  logic [3:0]  exp_sel;
  logic [31:0] exp_adr, exp_dat, exp_rdat;

  int          cyc_hi;
  logic [31:0] last_rdat, last_wdat;
  logic        last_rerr, last_rto;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc", 32'(wbm_cyc_o), 32'(exp_cyc));
      chk("stb", 32'(wbm_stb_o), 32'(exp_cyc));
      chk("we", 32'(wbm_we_o), 32'(exp_we));
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(!exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rvalid));
      if (exp_chk_bus) begin
        chk("sel", 32'(wbm_sel_o), 32'(exp_sel));
        chk("adr", wbm_adr_o, exp_adr);
        chk("dat_o", wbm_dat_o, exp_dat);
      end
      if (exp_chk_rsp) begin
        chk("rsp_dat", rsp_dat, exp_rdat);
        chk("rsp_err", 32'(rsp_err), 32'(exp_rerr));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_rto));
      end
    end
    if (wbm_cyc_o) begin
      cyc_hi++;
      last_wdat = wbm_dat_o;
    end
    if (rsp_valid) begin
      last_rdat = rsp_dat;
      last_rerr = rsp_err;
      last_rto  = rsp_timeout;
    end
  end

  task automatic exp_idle();
    exp_cyc = 0; exp_we = 0; exp_ready = 1; exp_rvalid = 0;
    exp_chk_bus = 0; exp_chk_rsp = 0;
  endtask

  task automatic exp_bus(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    exp_cyc = 1; exp_we = we; exp_ready = 0; exp_rvalid = 0;
    exp_chk_bus = 1; exp_chk_rsp = 0;
    exp_sel = sel; exp_adr = adr; exp_dat = dat;
  endtask

  task automatic exp_resp(input logic [31:0] d, input logic e, input logic t);
    exp_cyc = 0; exp_we = 0; exp_ready = 0; exp_rvalid = 1;
    exp_chk_bus = 0; exp_chk_rsp = 1;
    exp_rdat = d; exp_rerr = e; exp_rto = t;
  endtask

  task automatic exp_reset();
    exp_idle();
    exp_chk_bus = 1; exp_sel = '0; exp_adr = '0; exp_dat = '0;
    exp_chk_rsp = 1; exp_rdat = '0; exp_rerr = 0; exp_rto = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_cmd();
    cmd_valid = 1'($urandom);
    cmd_we    = 1'($urandom);
    cmd_sel   = 4'($urandom);
    cmd_adr   = $urandom;
    cmd_dat   = $urandom;
  endtask

  // kind: 0 ack, 1 err, 2 ack+err together, 3 no response (timeout)
  task automatic txn(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat,
                     input int lat, input int kind, input logic [31:0] rdat, input int stall);
    int nbus;
    logic [31:0] e_dat;
    logic e_err, e_to;
    cyc_hi    = 0;
    cmd_valid = 1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
    wbm_ack_i = 1'($urandom); wbm_err_i = 1'($urandom); rsp_ready = 1'($urandom);
    tick();
    nbus = (kind == 3) ? int'(TO) : lat;
    for (int i = 1; i <= nbus; i++) begin
      exp_bus(we, sel, adr, dat);
      junk_cmd();
      rsp_ready = 1'($urandom);
      wbm_ack_i = (i == nbus) && (kind == 0 || kind == 2);
      wbm_err_i = (i == nbus) && (kind == 1 || kind == 2);
      wbm_dat_i = (i == nbus) ? rdat : $urandom;
      tick();
    end
    e_dat = ((kind == 0 || kind == 2) && !we) ? rdat : 32'h0;
    e_err = (kind == 1);
    e_to  = (kind == 3);
    for (int j = 0; j <= stall; j++) begin
      exp_resp(e_dat, e_err, e_to);
      junk_cmd();
      cmd_valid = 1;
      wbm_ack_i = 1'($urandom); wbm_err_i = 1'($urandom); wbm_dat_i = $urandom;
      rsp_ready = (j == stall);
      tick();
    end
    exp_idle();
    cmd_valid = 0; wbm_ack_i = 0; wbm_err_i = 0; rsp_ready = 0;
  endtask

  // Start a read the slave never answers, hold it nb cycles, then pulse reset and send a late ack
  task automatic bus_then_reset(input int nb);
    cyc_hi = 0;
    cmd_valid = 1; cmd_we = 0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0010; cmd_dat = 32'h0;
    tick();
    for (int i = 1; i <= nb; i++) begin
      exp_bus(0, 4'hF, 32'h3000_0010, 32'h0);
      cmd_valid = 0; wbm_ack_i = 0; wbm_err_i = 0;
      reset = (i == nb);
      tick();
    end
    exp_reset();
    reset = 0;
    wbm_ack_i = 1; wbm_dat_i = 32'hBAD0_BAD0; rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_idle();
    end
    wbm_ack_i = 0;
  endtask

  initial begin
    int kmax;
    last_rdat = '0; last_wdat = '0; last_rerr = 0; last_rto = 0; cyc_hi = 0;
    exp_reset();
    reset = 1;
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    tick();
    exp_idle();

    // Write, ack on 2nd stb cycle
    txn(1, 4'hF, 32'h3000_0000, 32'hA5A5_1234, 2, 0, 32'h1111_2222, 0);
    chk("t1_cyc_cycles", 32'(cyc_hi), 32'd2);
    chk("t1_wdat", last_wdat, 32'hA5A5_1234);
    chk("t1_rsp_dat", last_rdat, 32'h0);
    tick();

    // Read, ack in first stb cycle
    txn(0, 4'h3, 32'h3000_0004, 32'h0, 1, 0, 32'hDEAD_BEEF, 0);
    chk("t2_cyc_cycles", 32'(cyc_hi), 32'd1);
    chk("t2_rsp_dat", last_rdat, 32'hDEAD_BEEF);

    // ack and err together, then err alone
    txn(0, 4'hF, 32'h3000_0008, 32'h0, 3, 2, 32'h1234_5678, 0);
    chk("t4_both_err", 32'(last_rerr), 32'd0);
    chk("t4_both_dat", last_rdat, 32'h1234_5678);
    txn(0, 4'hF, 32'h3000_000C, 32'h0, 2, 1, 32'h5555_AAAA, 0);
    chk("t4_err", 32'(last_rerr), 32'd1);
    chk("t4_err_dat", last_rdat, 32'h0);

    // Response back-pressure for 5 cycles with a pending command
    txn(1, 4'h5, 32'h3000_0020, 32'hCAFE_0001, 2, 0, 32'h0, 5);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    txn(0, 4'hF, 32'h3000_0030, 32'h0, 0, 3, 32'h0, 1);
    chk("t3_cyc_cycles", 32'(cyc_hi), 32'd16);
    chk("t3_timeout", 32'(last_rto), 32'd1);
    chk("t3_dat", last_rdat, 32'h0);
    kmax = 3;
`else
    bus_then_reset(100);
    chk("t3_cyc_cycles", 32'(cyc_hi), 32'd100);
    kmax = 2;
`endif

    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(kmax, 0));
      txn(1'($urandom), 4'($urandom), $urandom, $urandom, int'($urandom_range(6, 1)), k,
          $urandom, int'($urandom_range(3, 0)));
      if ($urandom_range(1, 0) == 1) tick();
    end

    bus_then_reset(3);
    txn(0, 4'h1, 32'h3000_0040, 32'h0, 1, 0, 32'h0BAD_F00D, 0);
    chk("t6_recover", last_rdat, 32'h0BAD_F00D);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
